// File: rtl/execute_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction codes, ALU
// functions, branch conditions and condition-code bit positions.
package y86_pkg;

   localparam int unsigned XLEN = 64;
   typedef logic [XLEN-1:0] word_t;

   localparam logic [3:0] I_HALT  = 4'h0;
   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_CMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OP    = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   localparam logic [3:0] C_ALWAYS = 4'h0;
   localparam logic [3:0] C_LE     = 4'h1;
   localparam logic [3:0] C_L      = 4'h2;
   localparam logic [3:0] C_E      = 4'h3;
   localparam logic [3:0] C_NE     = 4'h4;
   localparam logic [3:0] C_GE     = 4'h5;
   localparam logic [3:0] C_G      = 4'h6;

   localparam int unsigned ZF = 0;
   localparam int unsigned SF = 1;
   localparam int unsigned OF = 2;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_AND = 2'd2,
      OP_XOR = 2'd3
   } alu_op_e;

   function automatic logic is_valid_op(input logic [3:0] ifun);
      return ifun <= ALU_XOR;
   endfunction

endpackage

// File: rtl/execute_if.sv
// Decode-to-execute operand bundle and the execute results returned downstream.
interface execute_if;
   logic [3:0]         icode;
   logic [3:0]         ifun;
   logic signed [63:0] valA;
   logic signed [63:0] valB;
   logic signed [63:0] valC;
   logic signed [63:0] valE;
   logic [2:0]         cnd;
   logic               jmpcnd;

   modport master (
      output icode, ifun, valA, valB, valC,
      input  valE, cnd, jmpcnd
   );

   modport slave (
      input  icode, ifun, valA, valB, valC,
      output valE, cnd, jmpcnd
   );
endinterface

// File: rtl/execute_alu.sv
// 64-bit integer ALU computing b OP a, with zero/sign/overflow flags.
import y86_pkg::*;

module alu (
   input  alu_op_e     i_op,
   input  logic [63:0] i_a,
   input  logic [63:0] i_b,
   output logic [63:0] o_result,
   output logic        o_zf,
   output logic        o_sf,
   output logic        o_of
);

   logic [63:0] w_res;
   logic        w_of;

   always_comb begin
      w_res = '0;
      w_of  = 1'b0;
      case (i_op)
         OP_ADD: begin
            w_res = i_b + i_a;
            w_of  = (i_a[63] == i_b[63]) && (w_res[63] != i_b[63]);
         end
         OP_SUB: begin
            w_res = i_b - i_a;
            w_of  = (i_a[63] != i_b[63]) && (w_res[63] != i_b[63]);
         end
         OP_AND: w_res = i_b & i_a;
         OP_XOR: w_res = i_b ^ i_a;
         default: begin
            w_res = '0;
            w_of  = 1'b0;
         end
      endcase
   end

   assign o_result = w_res;
   assign o_zf     = (w_res == '0);
   assign o_sf     = w_res[63];
   assign o_of     = w_of;

endmodule

// File: rtl/execute.sv
// Y86-64 execute stage: valE selection, condition-code register and the
// jXX/cmovXX condition evaluated from the stored flags.
import y86_pkg::*;

module execute (
   input  logic     clk,
   input  logic     reset,
   execute_if.slave bus
);

   logic [63:0] w_alu_res;
   logic        w_zf;
   logic        w_sf;
   logic        w_of;
   logic        w_cc_load;
   logic [63:0] w_valE;
   logic        w_jmpcnd;
   logic [2:0]  r_cnd;

   alu u_alu (
      .i_op     (alu_op_e'(bus.ifun[1:0])),
      .i_a      (bus.valA),
      .i_b      (bus.valB),
      .o_result (w_alu_res),
      .o_zf     (w_zf),
      .o_sf     (w_sf),
      .o_of     (w_of)
   );

   assign w_cc_load = (bus.icode == I_OP) && is_valid_op(bus.ifun);

   always_comb begin
      w_valE = '0;
      case (bus.icode)
         I_HALT, I_NOP, I_JXX: w_valE = '0;
         I_CMOV:               w_valE = bus.valA;
         I_IRMOV:              w_valE = bus.valC;
         I_RMMOV, I_MRMOV:     w_valE = bus.valB + bus.valC;
         I_OP:                 w_valE = w_cc_load ? w_alu_res : '0;
         I_CALL, I_PUSH:       w_valE = bus.valB - 64'd8;
         I_RET, I_POP:         w_valE = bus.valB + 64'd8;
         default:              w_valE = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnd <= '0;
      end else if (w_cc_load) begin
         r_cnd[ZF] <= w_zf;
         r_cnd[SF] <= w_sf;
         r_cnd[OF] <= w_of;
      end
   end

   // Condition uses the stored flags, so an OPq sees its predecessor's flags.
   always_comb begin
      w_jmpcnd = 1'b0;
      case (bus.ifun)
         C_ALWAYS: w_jmpcnd = 1'b1;
         C_LE:     w_jmpcnd = (r_cnd[SF] ^ r_cnd[OF]) | r_cnd[ZF];
         C_L:      w_jmpcnd = r_cnd[SF] ^ r_cnd[OF];
         C_E:      w_jmpcnd = r_cnd[ZF];
         C_NE:     w_jmpcnd = ~r_cnd[ZF];
         C_GE:     w_jmpcnd = ~(r_cnd[SF] ^ r_cnd[OF]);
         C_G:      w_jmpcnd = ~(r_cnd[SF] ^ r_cnd[OF]) & ~r_cnd[ZF];
         default:  w_jmpcnd = 1'b0;
      endcase
   end

   assign bus.valE   = w_valE;
   assign bus.cnd    = r_cnd;
   assign bus.jmpcnd = w_jmpcnd;

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for the execute stage: directed instructions push expected
// valE/cnd/jmpcnd values; a negedge monitor pops and compares them.
module tb_execute;

   logic clk;
   logic reset;

   execute_if bus ();

   execute dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int K_VALE = 0;
   localparam int K_CND  = 1;
   localparam int K_JMP  = 2;

   typedef struct {
      string       name;
      int          kind;
      logic [63:0] exp;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic stim_done = 1'b0;

   // Monitor: everything queued during a cycle is checked at that cycle's negedge.
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] act;
      while (q.size() > 0) begin
         e = q.pop_front();
         case (e.kind)
            K_VALE:  act = bus.valE;
            K_CND:   act = {61'd0, bus.cnd};
            default: act = {63'd0, bus.jmpcnd};
         endcase
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
         end
      end
   end

   task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c);
      @(posedge clk);
      #1;
      bus.icode = ic;
      bus.ifun  = fn;
      bus.valA  = a;
      bus.valB  = b;
      bus.valC  = c;
   endtask

   task automatic expect_e(input string n, input logic [63:0] v);
      q.push_back('{name: n, kind: K_VALE, exp: v});
   endtask

   task automatic expect_c(input string n, input logic [2:0] v);
      q.push_back('{name: n, kind: K_CND, exp: {61'd0, v}});
   endtask

   task automatic expect_j(input string n, input logic v);
      q.push_back('{name: n, kind: K_JMP, exp: {63'd0, v}});
   endtask

   initial begin
      reset     = 1'b1;
      bus.icode = 4'h0;
      bus.ifun  = 4'h0;
      bus.valA  = '0;
      bus.valB  = '0;
      bus.valC  = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      expect_c("reset_cnd", 3'b000);
      expect_e("halt_valE", 64'd0);

      issue(4'h6, 4'h0, 64'd25, 64'd20, 64'd0);
      expect_e("add_45", 64'd45);
      issue(4'h6, 4'h1, 64'd20, 64'd20, 64'd0);
      expect_c("add_45_cnd", 3'b000);
      expect_e("sub_zero", 64'd0);
      issue(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
      expect_c("sub_zero_cnd", 3'b001);
      expect_j("je_after_zero", 1'b1);
      expect_e("jxx_valE", 64'd0);
      issue(4'h7, 4'h4, 64'd0, 64'd0, 64'd0);
      expect_j("jne_after_zero", 1'b0);
      expect_c("jxx_holds_cnd", 3'b001);

      // xor with ifun 3 reads the old ZF, not its own nonzero result
      issue(4'h6, 4'h3, 64'd5, 64'd3, 64'd0);
      expect_e("xor_6", 64'd6);
      expect_j("op_sees_old_flags", 1'b1);
      issue(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
      expect_c("xor_cnd", 3'b000);
      expect_j("je_after_xor", 1'b0);

      issue(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
      expect_e("add_ovf", 64'h8000_0000_0000_0000);
      issue(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
      expect_c("add_ovf_cnd", 3'b110);
      expect_j("jl_ovf", 1'b0);
      issue(4'h7, 4'h6, 64'd0, 64'd0, 64'd0);
      expect_j("jg_ovf", 1'b1);
      issue(4'h7, 4'h1, 64'd0, 64'd0, 64'd0);
      expect_j("jle_ovf", 1'b0);

      issue(4'h6, 4'h1, 64'd5, 64'd3, 64'd0);
      expect_e("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE);
      issue(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
      expect_c("sub_neg_cnd", 3'b010);
      expect_j("jl_neg", 1'b1);
      issue(4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
      expect_j("jge_neg", 1'b0);

      issue(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
      expect_e("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF);
      issue(4'h6, 4'h2, 64'hF0, 64'h3C, 64'd0);
      expect_c("sub_ovf_cnd", 3'b100);
      expect_e("and_30", 64'h30);

      issue(4'h6, 4'h0, 64'd25, 64'd20, 64'd0);
      expect_c("and_cnd", 3'b000);
      issue(4'h2, 4'h6, 64'd15, 64'd20, 64'd0);
      expect_e("cmovg_valE", 64'd15);
      expect_j("cmovg_cnd", 1'b1);
      issue(4'h4, 4'h0, 64'd0, 64'd100, 64'd8);
      expect_c("cmov_no_cc", 3'b000);
      expect_e("rmmovq", 64'd108);
      issue(4'h5, 4'h0, 64'd0, 64'd100, 64'd8);
      expect_e("mrmovq", 64'd108);
      issue(4'h8, 4'h0, 64'd0, 64'd64, 64'd0);
      expect_e("call", 64'd56);
      issue(4'h9, 4'h0, 64'd0, 64'd64, 64'd0);
      expect_e("ret", 64'd72);
      issue(4'hA, 4'h0, 64'd0, 64'd64, 64'd0);
      expect_e("pushq", 64'd56);
      issue(4'hB, 4'h0, 64'd0, 64'd64, 64'd0);
      expect_e("popq", 64'd72);
      issue(4'h3, 4'h0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB);
      expect_e("irmovq_neg", 64'hFFFF_FFFF_FFFF_FFFB);
      issue(4'hC, 4'h0, 64'd7, 64'd9, 64'd11);
      expect_e("icode_c", 64'd0);
      issue(4'h1, 4'h0, 64'd7, 64'd9, 64'd11);
      expect_e("nop", 64'd0);

      issue(4'h6, 4'h1, 64'd5, 64'd3, 64'd0);
      expect_e("sub_neg2", 64'hFFFF_FFFF_FFFF_FFFE);
      issue(4'h6, 4'h5, 64'd1, 64'd2, 64'd0);
      expect_c("sub_neg2_cnd", 3'b010);
      expect_e("op_invalid_valE", 64'd0);
      issue(4'h6, 4'h0, 64'd0, 64'd0, 64'd0);
      expect_c("op_invalid_holds", 3'b010);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      bus.icode = 4'h1;
      expect_c("reset_beats_op", 3'b000);

      stim_done = 1'b1;
   end

   initial begin
      int cycles = 0;
      while (!stim_done && cycles < 2000) begin
         @(posedge clk);
         cycles++;
      end
      if (!stim_done) begin
         errors++;
         $display("FAIL stimulus_timeout: got %0d cycles expected completion", cycles);
      end
      repeat (2) @(posedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/execute.md
# execute

Y86-64 sequential-processor execute stage. It computes `valE` for every instruction class and holds the condition-code register (ZF/SF/OF). It evaluates the branch/conditional-move condition from the stored flags. It sits between decode (which supplies `valA`, `valB`, `valC`) and memory/write-back (which consume `valE` and `jmpcnd`).

## Interface
- No parameters; datapath width fixed at 64 bits.
- `clk`: input, 1 bit. Single clock; condition codes update on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `icode`: input, 4 bits. Instruction code.
- `ifun`: input, 4 bits. Function code.
- `valA`: input, 64 bits, signed. Operand A from decode.
- `valB`: input, 64 bits, signed. Operand B from decode.
- `valC`: input, 64 bits, signed. Immediate or displacement.
- `valE`: output, 64 bits, signed. Execute result; combinational.
- `cnd`: output, 3 bits. Registered condition codes: `cnd[0]`=ZF, `cnd[1]`=SF, `cnd[2]`=OF.
- `jmpcnd`: output, 1 bit. Condition for jXX/cmovXX, derived combinationally from registered `cnd`.

## Operation
- `valE` by icode:
  - 0 halt, 1 nop: 0.
  - 2 cmovXX: `valA`.
  - 3 irmovq: `valC`.
  - 4 rmmovq, 5 mrmovq: `valB + valC`.
  - 6 OPq:
    - ifun 0: `valB + valA`.
    - ifun 1: `valB - valA`.
    - ifun 2: `valB & valA`.
    - ifun 3: `valB ^ valA`.
    - ifun 4–15: 0.
  - 7 jXX: 0.
  - 8 call, A pushq: `valB - 8`.
  - 9 ret, B popq: `valB + 8`.
  - C–F: 0.
- All arithmetic is 64-bit two's complement and wraps silently.
- Flags, computed for OPq with ifun 0–3:
  - ZF = (result == 0).
  - SF = result[63].
  - OF for add: operands have equal sign and the result sign differs from them.
  - OF for sub: `valB` and `valA` signs differ and the result sign differs from `valB`'s.
  - OF for and/xor: 0.
- `jmpcnd` by ifun, using registered flags:
  - 0: 1 (always).
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: ~ZF.
  - 5 ge: ~(SF^OF).
  - 6 g: ~(SF^OF)&~ZF.
  - 7–15: 0.
- `jmpcnd` is meaningful only for icode 2 and 7. It is driven for every icode, and downstream stages ignore it otherwise.

## Timing
- `valE` and `jmpcnd` are purely combinational, with zero latency from the inputs and from the CC register.
- CC register:
  - Reset: `cnd` = 3'b000.
  - Loads on a rising edge of `clk` when icode=6 and ifun≤3.
  - Holds for all other icodes and for invalid OPq ifun.
- Reset wins over a simultaneous OPq: CC clears.
- `cnd` changes only after the edge. A cmov/jXX issued the cycle after an OPq sees the flags produced by that OPq.
- An OPq's own `jmpcnd` reflects the previous flags, not its own result.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants: I_HALT, I_NOP, I_CMOV, I_IRMOV, I_RMMOV, I_MRMOV, I_OP, I_JXX, I_CALL, I_RET, I_PUSH, I_POP.
  - ALU function constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR.
  - Condition constants: C_ALWAYS, C_LE, C_L, C_E, C_NE, C_GE, C_G.
  - CC bit-index constants: ZF=0, SF=1, OF=2.
- One sub-module `alu`: 64-bit add/sub/and/xor with a result output and ZF/SF/OF flag outputs.
- The top level contains the valE mux, the CC register and the condition logic.

## Test plan
- Reset, then icode=6 ifun=0 valA=25 valB=20 → `valE`=45; after the edge `cnd`=000.
- icode=6 ifun=1 valA=20 valB=20 → `valE`=0; after the edge `cnd`=001. Then icode=7 ifun=3 → `jmpcnd`=1, and ifun=4 → `jmpcnd`=0.
- icode=6 ifun=0 valA=1 valB=0x7FFF_FFFF_FFFF_FFFF → `valE`=0x8000_0000_0000_0000; after the edge `cnd`=110. Then icode=7 ifun=2 → `jmpcnd`=0, and ifun=6 → `jmpcnd`=1.
- After flags 000: icode=2 ifun=6 valA=15 valB=20 → `valE`=15 and `jmpcnd`=1. After the edge `cnd` stays 000 (no CC update).
- Address and stack results:
  - icode=4 valB=100 valC=8 → `valE`=108.
  - icode=8 valB=64 → `valE`=56.
  - icode=9 valB=64 → `valE`=72.
  - icode=3 valC=-5 → `valE`=-5.
- Set flags nonzero via sub, then assert `reset` together with icode=6 → `cnd`=000 after the edge. Then icode=6 ifun=5 → `valE`=0 and `cnd` unchanged after the edge.
